imem_loader: RTL

- Boot-time program loader that sits directly upstream of the single-cycle processor.
- Receives a framed byte stream (from a host link) over a valid/ready handshake.
- Packs bytes into 32-bit big-endian words and writes them into instruction memory through a write port.
- Holds the processor in reset until a complete, checksum-verified image is loaded, then releases it.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Holds the loader state encoding and frame-format widths.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    CHECK,
    RUN,
    ERR
  } state_t;

  localparam int HDR_LEN = 2;
  localparam int CSUM_W  = 8;
  localparam int WORD_W  = 32;
  localparam int NCNT_W  = CSUM_W * HDR_LEN;

  // States in which a frame is being received and bytes are accepted.
  function automatic logic in_load(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == PAYLOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = host link / memory side.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              byte_valid;
  logic [CSUM_W-1:0] byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid pulses one cycle
// after the 4th byte of a word. No backpressure: consumes whatever byte_en presents.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [CSUM_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  logic [1:0] lane;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lane       <= 2'd0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= 2'd0;
      end else if (byte_en) begin
        word_data  <= {word_data[WORD_W-CSUM_W-1:0], byte_data};
        lane       <= lane + 2'd1;
        word_valid <= (lane == 2'd3);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed, XOR-checksummed byte image and writes it into instruction memory,
// holding the CPU in reset until verified. byte_ready is a registered state decode.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 8,
  parameter logic [WORD_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [NCNT_W-1:0] word_count
);

  state_t              state;
  state_t              state_nxt;
  logic                byte_ready;
  logic                fire;
  logic                enter_hdr;
  logic                too_big;
  logic [CSUM_W-1:0]   csum;
  logic [CSUM_W-1:0]   n_hi;
  logic [NCNT_W-1:0]   n_rx;
  logic [NCNT_W+1:0]   rem;
  logic [ADDR_WIDTH:0] index;
  logic                word_valid;
  logic [WORD_W-1:0]   word_data;

  assign bus.byte_ready = byte_ready;
  assign fire           = bus.byte_valid && byte_ready;
  assign n_rx           = {n_hi, bus.byte_data};
  assign too_big        = (32'(n_rx) > (32'd1 << ADDR_WIDTH));
  assign enter_hdr      = (state_nxt == HDR_HI) && (state != HDR_HI);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, ERR: if (start) state_nxt = HDR_HI;
      HDR_HI:         if (fire)  state_nxt = HDR_LO;
      HDR_LO: begin
        if (fire) begin
          if (too_big)           state_nxt = ERR;
          else if (n_rx == '0)   state_nxt = CHECK;
          else                   state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: if (fire && (rem == (NCNT_W+2)'(1))) state_nxt = CHECK;
      CHECK:   if (fire) state_nxt = (bus.byte_data == csum) ? RUN : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_ready <= in_load(state_nxt);
      busy       <= in_load(state_nxt);
      cpu_reset  <= (state_nxt != RUN);
      done       <= (state_nxt == RUN);
      error      <= (state_nxt == ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      csum       <= '0;
      n_hi       <= '0;
      rem        <= '0;
      index      <= '0;
      word_count <= '0;
    end else begin
      if (enter_hdr) begin
        csum  <= '0;
        index <= '0;
      end else begin
        if (fire && (state != CHECK)) csum <= csum ^ bus.byte_data;
        if (word_valid)               index <= index + 1'b1;
      end
      if (fire && (state == HDR_HI)) n_hi <= bus.byte_data;
      if (fire && (state == HDR_LO)) begin
        word_count <= n_rx;
        rem        <= {n_rx, 2'b00};
      end
      if (fire && (state == PAYLOAD)) rem <= rem - 1'b1;
    end
  end

  imem_loader_word_packer u_word_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_hdr),
    .byte_en    (fire && (state == PAYLOAD)),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // Address and data are forced to zero outside the write strobe.
  assign bus.imem_we    = word_valid;
  assign bus.imem_wdata = word_valid ? word_data : '0;
  assign bus.imem_addr  = word_valid ? (BASE_ADDR + (32'(index) << 2)) : '0;

endmodule
